// File: rtl/cla_pipelined_addsub.sv
// cla_pipelined_addsub: pipelined carry-lookahead adder/subtractor.
// One BLOCK-bit lookahead group per register stage, valid/ready on both sides.
module cla_pipelined_addsub #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int G = WIDTH / BLOCK;

  if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_bad
    $error("WIDTH must be a multiple of BLOCK");
  end

  function automatic logic [BLOCK:0] lookahead(
    input logic [BLOCK-1:0] p,
    input logic [BLOCK-1:0] g,
    input logic             c0
  );
    logic [BLOCK:0] c;
    logic           t;
    c[0] = c0;
    for (int i = 1; i <= BLOCK; i++) begin
      t    = 1'b1;
      c[i] = 1'b0;
      for (int j = i - 1; j >= 0; j--) begin
        c[i] = c[i] | (t & g[j]);
        t    = t & p[j];
      end
      c[i] = c[i] | (t & c0);
    end
    return c;
  endfunction

  logic adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // x rotates right one group per stage: operand bits leave the
  // bottom, finished sum bits enter the top, so after G stages x = sum.
  for (genvar k = 0; k < G; k++) begin : gs
    localparam int RW = WIDTH - k * BLOCK;

    logic             vi;
    logic             ci;
    logic [WIDTH-1:0] xi;
    logic [WIDTH-1:0] xn;
    logic [RW-1:0]    bi;
    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] s;
    logic [BLOCK:0]   c;
    logic             v_q;
    logic [WIDTH-1:0] x_q;
    logic             c_q;

    if (k == 0) begin : g_in
      assign vi = in_valid;
      assign xi = a;
      assign bi = b ^ {WIDTH{sub}};
      assign ci = cin ^ sub;
    end else begin : g_chain
      assign vi = gs[k-1].v_q;
      assign xi = gs[k-1].x_q;
      assign bi = gs[k-1].g_skew.b_q;
      assign ci = gs[k-1].c_q;
    end

    assign p = xi[BLOCK-1:0] ^ bi[BLOCK-1:0];
    assign g = xi[BLOCK-1:0] & bi[BLOCK-1:0];
    assign c = lookahead(p, g, ci);
    assign s = p ^ c[BLOCK-1:0];

    if (G == 1) begin : g_one
      assign xn = s;
    end else begin : g_rot
      assign xn = {s, xi[WIDTH-1:BLOCK]};
    end

    if (k < G - 1) begin : g_skew
      logic [RW-BLOCK-1:0] b_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q <= 1'b0;
          x_q <= '0;
          c_q <= 1'b0;
          b_q <= '0;
        end else if (adv) begin
          v_q <= vi;
          x_q <= xn;
          c_q <= c[BLOCK];
          b_q <= bi[RW-1:BLOCK];
        end
      end
    end else begin : g_out
      logic o_q;

      // Result registers only load real beats, so they hold across bubbles.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q <= 1'b0;
          x_q <= '0;
          c_q <= 1'b0;
          o_q <= 1'b0;
        end else if (adv) begin
          v_q <= vi;
          if (vi) begin
            x_q <= xn;
            c_q <= c[BLOCK];
            o_q <= c[BLOCK-1] ^ c[BLOCK];
          end
        end
      end
    end
  end

  assign out_valid = gs[G-1].v_q;
  assign sum       = gs[G-1].x_q;
  assign cout      = gs[G-1].c_q;
  assign ovf       = gs[G-1].g_out.o_q;

endmodule
